// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions for the display-bus encoder and the scan decoder.
//   SEG_0..SEG_9, SEG_BLANK : segment patterns {a,b,c,d,e,f,g}, a = bit 6, active-high
//   BCD_BLANK, BCD_INVALID  : BCD codes reported for blank and non-decimal patterns
//   state_e                 : scan decoder FSM states
package seven_seg_pkg;

   localparam logic [6:0] SEG_0     = 7'b1111110;
   localparam logic [6:0] SEG_1     = 7'b0110000;
   localparam logic [6:0] SEG_2     = 7'b1101101;
   localparam logic [6:0] SEG_3     = 7'b1111001;
   localparam logic [6:0] SEG_4     = 7'b0110011;
   localparam logic [6:0] SEG_5     = 7'b1011011;
   localparam logic [6:0] SEG_6     = 7'b1011111;
   localparam logic [6:0] SEG_7     = 7'b1110000;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1111011;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   localparam logic [3:0] BCD_BLANK   = 4'hF;
   localparam logic [3:0] BCD_INVALID = 4'hE;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      CAPTURED
   } state_e;

endpackage

// File: rtl/seven_segment_scan_decoder_if.sv
// Display-bus monitor interface.
//   seg_in      : segment lines {a..g}
//   dig_sel     : one-hot digit select
//   bcd_out     : recovered digits, digit i at [4i+3:4i]
//   blank_mask  : digit i was blank
//   err_mask    : digit i held a non-decimal pattern
//   frame_valid : one-cycle pulse when the outputs update
//   frame_err   : OR of err_mask for the published frame
// master drives the bus and observes results; slave is the decoder.
interface seven_segment_scan_decoder_if #(
   parameter int unsigned NUM_DIGITS = 4
);
   logic [6:0]              seg_in;
   logic [NUM_DIGITS-1:0]   dig_sel;
   logic [4*NUM_DIGITS-1:0] bcd_out;
   logic [NUM_DIGITS-1:0]   blank_mask;
   logic [NUM_DIGITS-1:0]   err_mask;
   logic                    frame_valid;
   logic                    frame_err;

   modport master (
      output seg_in, dig_sel,
      input  bcd_out, blank_mask, err_mask, frame_valid, frame_err
   );

   modport slave (
      input  seg_in, dig_sel,
      output bcd_out, blank_mask, err_mask, frame_valid, frame_err
   );
endinterface

// File: rtl/seg7_pattern_decode.sv
// Combinational seven-segment pattern to BCD decoder.
//   seg   : segment pattern {a..g}, active-high
//   bcd   : decoded digit; BCD_BLANK when blank, BCD_INVALID when non-decimal
//   blank : all segments off
//   err   : pattern is neither a decimal digit nor blank
module seg7_pattern_decode
   import seven_seg_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] bcd,
   output logic       blank,
   output logic       err
);

   always_comb begin
      bcd   = BCD_INVALID;
      blank = 1'b0;
      err   = 1'b0;
      case (seg)
         SEG_0:     bcd = 4'd0;
         SEG_1:     bcd = 4'd1;
         SEG_2:     bcd = 4'd2;
         SEG_3:     bcd = 4'd3;
         SEG_4:     bcd = 4'd4;
         SEG_5:     bcd = 4'd5;
         SEG_6:     bcd = 4'd6;
         SEG_7:     bcd = 4'd7;
         SEG_8:     bcd = 4'd8;
         SEG_9:     bcd = 4'd9;
         SEG_BLANK: begin
            bcd   = BCD_BLANK;
            blank = 1'b1;
         end
         default:   err = 1'b1;
      endcase
   end

endmodule

// File: rtl/seven_segment_scan_decoder.sv
// Seven-segment scan decoder: watches a multiplexed display bus, waits for each digit
// select to settle, decodes its segments back to BCD and publishes whole frames.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : seven_segment_scan_decoder_if.slave (bus inputs, frame outputs)
// Build option: define SEG_ACTIVE_LOW_EN for a common-anode bus (inputs inverted
// before the input register).
module seven_segment_scan_decoder
   import seven_seg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS    = 4,
   parameter int unsigned SETTLE_CYCLES = 3,
   parameter int unsigned SETTLE_W      = $clog2(SETTLE_CYCLES + 1)
) (
   input logic                      clk,
   input logic                      rst_n,
   seven_segment_scan_decoder_if.slave bus
);

   localparam logic [SETTLE_W-1:0] SETTLE_MAX = SETTLE_W'(SETTLE_CYCLES);
   localparam logic [SETTLE_W-1:0] SETTLE_ONE = SETTLE_W'(1);
   localparam bit                  SINGLE     = (SETTLE_CYCLES == 1);

   logic [6:0]              seg_pre, seg_q;
   logic [NUM_DIGITS-1:0]   sel_pre, sel_q, cur_q;
   state_e                  state_q;
   logic [SETTLE_W-1:0]     cnt_q, cnt_inc;
   logic [NUM_DIGITS-1:0]   seen_q, seen_d;
   logic [4*NUM_DIGITS-1:0] shadow_bcd_q, bcd_q;
   logic [NUM_DIGITS-1:0]   shadow_blank_q, shadow_err_q, blank_q, err_q;
   logic                    valid_q, ferr_q;
   logic [3:0]              dec_bcd;
   logic                    dec_blank, dec_err;
   logic                    sel_onehot, fresh, do_capture, frame_done;

`ifdef SEG_ACTIVE_LOW_EN
   assign seg_pre = ~bus.seg_in;
   assign sel_pre = ~bus.dig_sel;
`else
   assign seg_pre = bus.seg_in;
   assign sel_pre = bus.dig_sel;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seg_q <= '0;
         sel_q <= '0;
      end else begin
         seg_q <= seg_pre;
         sel_q <= sel_pre;
      end
   end

   seg7_pattern_decode u_decode (
      .seg   (seg_q),
      .bcd   (dec_bcd),
      .blank (dec_blank),
      .err   (dec_err)
   );

   assign sel_onehot = (sel_q != '0) && ((sel_q & (sel_q - 1'b1)) == '0);
   // A new select restarts settling; in SETTLE/CAPTURED cur_q is last edge's sel_q.
   assign fresh      = sel_onehot && ((state_q == IDLE) || (sel_q != cur_q));
   assign cnt_inc    = cnt_q + SETTLE_ONE;
   assign do_capture = sel_onehot &&
                       (fresh ? SINGLE : ((state_q == SETTLE) && (cnt_inc == SETTLE_MAX)));
   assign frame_done = &seen_q;
   // Clear on publish first, so a capture on the same edge opens the next frame.
   assign seen_d     = (frame_done ? '0 : seen_q) | (do_capture ? sel_q : '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         cur_q   <= '0;
      end else if (!sel_onehot) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else if (fresh) begin
         cur_q   <= sel_q;
         cnt_q   <= SETTLE_ONE;
         state_q <= do_capture ? CAPTURED : SETTLE;
      end else if (state_q == SETTLE) begin
         cnt_q <= cnt_inc;
         if (do_capture) state_q <= CAPTURED;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seen_q         <= '0;
         shadow_bcd_q   <= {NUM_DIGITS{BCD_BLANK}};
         shadow_blank_q <= '1;
         shadow_err_q   <= '0;
         bcd_q          <= {NUM_DIGITS{BCD_BLANK}};
         blank_q        <= '1;
         err_q          <= '0;
         valid_q        <= 1'b0;
         ferr_q         <= 1'b0;
      end else begin
         seen_q  <= seen_d;
         valid_q <= frame_done;
         if (frame_done) begin
            bcd_q   <= shadow_bcd_q;
            blank_q <= shadow_blank_q;
            err_q   <= shadow_err_q;
            ferr_q  <= |shadow_err_q;
         end
         for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (do_capture && sel_q[i]) begin
               shadow_bcd_q[4*i +: 4] <= dec_bcd;
               shadow_blank_q[i]      <= dec_blank;
               shadow_err_q[i]        <= dec_err;
            end
         end
      end
   end

   assign bus.bcd_out     = bcd_q;
   assign bus.blank_mask  = blank_q;
   assign bus.err_mask    = err_q;
   assign bus.frame_valid = valid_q;
   assign bus.frame_err   = ferr_q;

endmodule
